// File: rtl/tt_prof_pkg.sv
// Shared types and helpers for the truth-table profiler: FSM states and
// the row-to-table-bit mapping (row 0 lands in the MSB).
package tt_prof_pkg;

   localparam int unsigned N_IN_DEF = 3;
   localparam int unsigned ROWS     = 2**N_IN_DEF;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE
   } state_e;

   function automatic int unsigned row_to_bit(input int unsigned r,
                                              input int unsigned rows = ROWS);
      return rows - 1 - r;
   endfunction

endpackage

// File: rtl/truth_table_profiler_sample_vote.sv
// Per-row majority voter: accumulates ones over the sample window and reports
// the majority and whether the samples disagreed, including the current sample.
module sample_vote #(
   parameter int unsigned SAMPLES = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic sample_en,
   input  logic resp,
   output logic majority,
   output logic disagree
);

   localparam int unsigned VW = $clog2(SAMPLES + 1);

   logic [VW-1:0] ones_q;
   logic [VW-1:0] ones_d;
   logic [VW-1:0] ones_next;

   // Counts already include this cycle's resp, so the verdict is ready on the last sample.
   always_comb begin
      ones_next = ones_q + VW'(resp);
      majority  = ones_next > VW'(SAMPLES / 2);
      disagree  = (ones_next != '0) && (ones_next != VW'(SAMPLES));
   end

   always_comb begin
      ones_d = ones_q;
      if (clear) begin
         ones_d = '0;
      end else if (sample_en) begin
         ones_d = ones_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ones_q <= '0;
      end else begin
         ones_q <= ones_d;
      end
   end

endmodule

// File: rtl/truth_table_profiler.sv
// Walks every input combination of a gate under test, majority-votes its
// response per row and assembles the gate's truth-table code.
module truth_table_profiler
   import tt_prof_pkg::*;
#(
   parameter int unsigned N_IN          = N_IN_DEF,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned SAMPLES       = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   output logic [N_IN-1:0]      stim,
   input  logic                 resp,
   output logic                 busy,
   output logic                 done,
   output logic [2**N_IN-1:0]   table_out,
   output logic                 table_valid,
   output logic                 glitch
);

   localparam int unsigned ROWS_L = 2**N_IN;
   localparam int unsigned MAXC   = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
   localparam int unsigned CW     = $clog2(MAXC + 1);

   localparam logic [N_IN-1:0] LAST_ROW    = N_IN'(ROWS_L - 1);
   localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0]   SAMPLE_LAST = CW'(SAMPLES - 1);

   state_e              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [N_IN-1:0]     stim_q, stim_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [ROWS_L-1:0]   table_q, table_d;
   logic                table_valid_q, table_valid_d;
   logic                glitch_q, glitch_d;

   logic                vote_clear;
   logic                vote_en;
   logic                vote_maj;
   logic                vote_dis;
   logic [N_IN-1:0]     bit_idx;

   assign bit_idx = N_IN'(row_to_bit(32'(stim_q), ROWS_L));

   sample_vote #(
      .SAMPLES (SAMPLES)
   ) u_vote (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (vote_clear),
      .sample_en (vote_en),
      .resp      (resp),
      .majority  (vote_maj),
      .disagree  (vote_dis)
   );

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      stim_d        = stim_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      table_d       = table_q;
      table_valid_d = table_valid_q;
      glitch_d      = glitch_q;
      vote_clear    = 1'b1;
      vote_en       = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d       = SETTLE;
               cnt_d         = '0;
               stim_d        = '0;
               busy_d        = 1'b1;
               glitch_d      = 1'b0;
               table_valid_d = 1'b0;
               table_d       = '0;
            end
         end

         SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d = SAMPLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         SAMPLE: begin
            vote_clear = 1'b0;
            vote_en    = 1'b1;
            if (cnt_q == SAMPLE_LAST) begin
               table_d[bit_idx] = vote_maj;
               if (vote_dis) begin
                  glitch_d = 1'b1;
               end
               cnt_d = '0;
               if (stim_q == LAST_ROW) begin
                  state_d = DONE;
               end else begin
                  stim_d  = stim_q + 1'b1;
                  state_d = SETTLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         DONE: begin
            state_d       = IDLE;
            done_d        = 1'b1;
            table_valid_d = 1'b1;
            busy_d        = 1'b0;
            stim_d        = '0;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Abort overrides everything once a run is underway, including DONE.
      if (abort && (state_q != IDLE)) begin
         state_d       = IDLE;
         cnt_d         = '0;
         stim_d        = '0;
         busy_d        = 1'b0;
         done_d        = 1'b0;
         table_valid_d = 1'b0;
         table_d       = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         stim_q        <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         table_q       <= '0;
         table_valid_q <= 1'b0;
         glitch_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         stim_q        <= stim_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         table_q       <= table_d;
         table_valid_q <= table_valid_d;
         glitch_q      <= glitch_d;
      end
   end

   assign stim        = stim_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign table_out   = table_q;
   assign table_valid = table_valid_q;
   assign glitch      = glitch_q;

endmodule

// File: tb/tb_truth_table_profiler.sv
// Directed bench for truth_table_profiler: a behavioural 3-input gate drives
// resp, and each step checks outputs against hand-computed values.
module tb_truth_table_profiler;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic [2:0] stim;
   logic       resp;
   logic       busy;
   logic       done;
   logic [7:0] table_out;
   logic       table_valid;
   logic       glitch;

   logic [7:0] gate_code;
   logic       force0;

   int n_cmp;
   int n_err;

   truth_table_profiler #(
      .N_IN          (3),
      .SETTLE_CYCLES (4),
      .SAMPLES       (3)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
      .stim        (stim),
      .resp        (resp),
      .busy        (busy),
      .done        (done),
      .table_out   (table_out),
      .table_valid (table_valid),
      .glitch      (glitch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Gate model: row r = stim, output = code bit (7 - r); force0 pulls it low.
   always_comb begin
      resp = force0 ? 1'b0 : gate_code[~stim];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_stim"},  32'(stim),        32'd0);
      chk({tag, "_busy"},  32'(busy),        32'd0);
      chk({tag, "_done"},  32'(done),        32'd0);
      chk({tag, "_table"}, 32'(table_out),   32'd0);
      chk({tag, "_tv"},    32'(table_valid), 32'd0);
      chk({tag, "_glit"},  32'(glitch),      32'd0);
   endtask

   // Issue start; returns positioned in cycle 0 (just after the start edge).
   task automatic kick(input logic [7:0] code, input bit with_abort);
      gate_code = code;
      tick();
      start = 1'b1;
      abort = with_abort;
      tick();
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic run_full(input string tag, input logic [7:0] code, input bit force_glitch,
                           input bit restart20, input bit abort_at_start,
                           input logic [7:0] exp_tab, input bit exp_glitch);
      int row;
      kick(code, abort_at_start);
      chk({tag, "_c0_busy"},  32'(busy),        32'd1);
      chk({tag, "_c0_tv"},    32'(table_valid), 32'd0);
      chk({tag, "_c0_table"}, 32'(table_out),   32'd0);
      chk({tag, "_c0_glit"},  32'(glitch),      32'd0);
      for (int k = 0; k < 57; k++) begin
         row = (k / 7 > 7) ? 7 : k / 7;
         chk({tag, "_stim"}, 32'(stim), 32'(row));
         chk({tag, "_done_early"}, 32'(done), 32'd0);
         if (force_glitch) force0 = (k == 54);
         if (restart20) start = (k == 20);
         tick();
      end
      force0 = 1'b0;
      start  = 1'b0;
      chk({tag, "_c57_done"},  32'(done),        32'd1);
      chk({tag, "_c57_busy"},  32'(busy),        32'd0);
      chk({tag, "_c57_stim"},  32'(stim),        32'd0);
      chk({tag, "_c57_tv"},    32'(table_valid), 32'd1);
      chk({tag, "_c57_table"}, 32'(table_out),   32'(exp_tab));
      chk({tag, "_c57_glit"},  32'(glitch),      32'(exp_glitch));
      tick();
      chk({tag, "_c58_done"},  32'(done),        32'd0);
      chk({tag, "_c58_tv"},    32'(table_valid), 32'd1);
      chk({tag, "_c58_table"}, 32'(table_out),   32'(exp_tab));
   endtask

   initial begin
      int done_seen;
      n_cmp     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      force0    = 1'b0;
      gate_code = 8'hE1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("rst");
      rst_n = 1'b1;
      tick();

      // Basic E1 run
      run_full("e1", 8'hE1, 1'b0, 1'b0, 1'b0, 8'hE1, 1'b0);

      // abort in IDLE has no effect on the held result
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();
      chk("idle_abort_busy",  32'(busy),        32'd0);
      chk("idle_abort_tv",    32'(table_valid), 32'd1);
      chk("idle_abort_table", 32'(table_out),   32'hE1);

      // Constant gates
      run_full("zero", 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      run_full("ones", 8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0);

      // One bad sample in row 111: majority holds, glitch sticks
      run_full("glitch", 8'hE1, 1'b1, 1'b0, 1'b0, 8'hE1, 1'b1);

      // Start while busy ignored
      run_full("restart", 8'hE1, 1'b0, 1'b1, 1'b0, 8'hE1, 1'b0);

      // Start and abort together in IDLE: start wins
      run_full("st_ab", 8'h96, 1'b0, 1'b0, 1'b1, 8'h96, 1'b0);

      // Abort at cycle 30
      kick(8'hE1, 1'b0);
      for (int k = 0; k < 30; k++) tick();
      chk("abort_c30_busy",  32'(busy),      32'd1);
      chk("abort_c30_table", 32'(table_out), 32'hE0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_c31_busy",  32'(busy),        32'd0);
      chk("abort_c31_stim",  32'(stim),        32'd0);
      chk("abort_c31_tv",    32'(table_valid), 32'd0);
      chk("abort_c31_table", 32'(table_out),   32'd0);
      done_seen = 0;
      for (int k = 0; k < 40; k++) begin
         if (done) done_seen++;
         tick();
      end
      chk("abort_no_done", 32'(done_seen), 32'd0);
      chk("abort_stim_idle", 32'(stim), 32'd0);

      // Reset mid-run at cycle 25
      kick(8'hE1, 1'b0);
      for (int k = 0; k < 25; k++) tick();
      chk("mid_c25_table", 32'(table_out), 32'hE0);
      chk("mid_c25_stim",  32'(stim),      32'd3);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("mid_rst");
      tick();
      tick();
      rst_n = 1'b1;
      chk_reset_vals("mid_rel");
      run_full("post_rst", 8'hE1, 1'b0, 1'b0, 1'b0, 8'hE1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
